sync_packet_fifo: RTL and testbench
===================================

# sync_packet_fifo

Single-clock FIFO with first-word-fall-through output, fill-level reporting, almost-full/almost-empty thresholds and an optional packet mode. In packet mode, written words stay invisible to the reader until committed, and can be rolled back with an abort. It is the single-clock-domain successor to our cross-clock FIFO wrapper, using the same in_/out_ handshake naming. It sits between framing/decoder stages that validate a packet only after its last word.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, entries; power of two, ≥2
- PACKET_MODE, 1, 1 = commit/abort gating; 0 = every accepted word is committed immediately
- AF_LEVEL, DEPTH-2, in_almost_full threshold (in_level ≥ AF_LEVEL)
- AE_LEVEL, 1, out_almost_empty threshold (out_level ≤ AE_LEVEL)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_shift  in  1  write request
- in_data  in  WIDTH  write word
- in_commit  in  1  publish all words written so far, including this cycle's (ignored if PACKET_MODE=0)
- in_abort  in  1  discard uncommitted words, including this cycle's (ignored if PACKET_MODE=0)
- in_full  out  1  no free entry; counts uncommitted words
- in_almost_full  out  1  in_level ≥ AF_LEVEL
- in_level  out  $clog2(DEPTH)+1  entries in use (committed + uncommitted)
- in_overflow  out  1  sticky: in_shift seen while in_full
- out_pop  in  1  consume head word
- out_data  out  WIDTH  head word; valid while out_nempty
- out_nempty  out  1  at least one committed word available
- out_almost_empty  out  1  out_level ≤ AE_LEVEL
- out_level  out  $clog2(DEPTH)+1  committed words available

## Operation
- State: wr_ptr (speculative), cm_ptr (committed), rd_ptr. Each pointer is $clog2(DEPTH)+1 bits and wraps modulo 2·DEPTH.
- Derived levels:
  - in_level = wr_ptr − rd_ptr
  - out_level = cm_ptr − rd_ptr
  - in_full = (in_level == DEPTH)
  - out_nempty = (out_level != 0)
- Write: in_shift && !in_full → mem[wr_ptr] ← in_data, wr_ptr+1. in_shift while in_full → word dropped, no pointer change, in_overflow ← 1.
- Read: out_pop && out_nempty → rd_ptr+1. out_pop while empty is ignored. out_data = mem[rd_ptr[low bits]], combinational read of registered storage.
- Commit (PACKET_MODE=1): cm_ptr ← next wr_ptr, so a word accepted in the same cycle is included.
- Abort: wr_ptr ← cm_ptr; a same-cycle shift is discarded; in_overflow ← 0.
- in_commit and in_abort in the same cycle: abort wins, commit is ignored.
- PACKET_MODE=0: cm_ptr ← next wr_ptr every cycle; in_commit and in_abort have no effect; in_overflow clears only on reset.
- Packet longer than DEPTH: in_full rises with out_nempty low and stays so. Upstream must abort; the block takes no automatic action.
- Reset (rst_n low at an edge): all pointers ← 0 and in_overflow ← 0, mid-packet or not.
  - Output values after reset: in_full 0, in_almost_full (AF_LEVEL==0), in_level 0, out_nempty 0, out_level 0, out_almost_empty 1.
  - out_data is undefined until out_nempty; storage is not cleared.

## Timing
- All flags and levels are functions of registers; they change only after a clock edge.
- Write-to-read latency: a word accepted and committed at edge k is visible at the output after edge k (out_nempty high, out_data valid); it can be popped at edge k+1.
- Simultaneous shift and pop:
  - When full: pop is accepted, shift is rejected, since in_full is sampled before the edge.
  - When empty: shift is accepted, pop is ignored.
  - Otherwise both are accepted and levels are unchanged.
- Abort takes effect at the edge; in_level, in_full and in_almost_full reflect the freed space the next cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset with PACKET_MODE=0, DEPTH=16: write 0x00..0x0F back-to-back → in_full=1 after the 16th edge, in_level=16; 17th shift dropped, in_overflow=1; pop all → 0x00..0x0F in order, out_nempty=0 after the last pop.
- PACKET_MODE=1: shift 0xA1,0xA2,0xA3 with no commit → out_nempty=0, in_level=3, out_level=0; commit in the cycle of the 0xA3 shift → next cycle out_level=3, head 0xA1.
- Shift 0xB1,0xB2, abort in the cycle of a 0xB3 shift → in_level returns to its prior value; a following packet 0xC1 plus commit reads out 0xC1 with no B words.
- Commit and abort together on one cycle → uncommitted words discarded, out_level unchanged.
- Full FIFO with shift and pop on one edge → head popped, new word rejected, in_level=15. Empty FIFO with shift and pop → word stored, out_level=1.
- Pointer wrap: 100 random packets (lengths 1–8, 20% aborted) with random pops → output sequence equals the scoreboard of committed words only; mid-packet rst_n low → all levels 0 and out_almost_empty=1 next cycle.

Source files
------------

// File: rtl/sync_packet_fifo.sv
// sync_packet_fifo: single-clock first-word-fall-through FIFO with fill
// levels, thresholds and optional commit/abort packet gating.
module sync_packet_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter bit PACKET_MODE = 1'b1,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_shift,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_commit,
  input  logic                     in_abort,
  output logic                     in_full,
  output logic                     in_almost_full,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic                     in_overflow,
  input  logic                     out_pop,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_nempty,
  output logic                     out_almost_empty,
  output logic [$clog2(DEPTH):0]   out_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic abort, commit, wr_en, rd_en;

  assign in_level         = wr_ptr_q - rd_ptr_q;
  assign out_level        = cm_ptr_q - rd_ptr_q;
  assign in_full          = (in_level == DEPTH_L);
  assign in_almost_full   = (in_level >= AF_L);
  assign out_nempty       = (out_level != '0);
  assign out_almost_empty = (out_level <= AE_L);
  assign in_overflow      = ovf_q;
  assign out_data         = mem_q[rd_ptr_q[AW-1:0]];

  // Abort outranks commit; a shift in an aborting cycle is never stored.
  assign abort  = PACKET_MODE && in_abort;
  assign commit = PACKET_MODE && in_commit && !in_abort;
  assign wr_en  = in_shift && !in_full && !abort;
  assign rd_en  = out_pop && out_nempty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (in_shift && in_full) ovf_d = 1'b1;
    if (abort) begin
      wr_ptr_d = cm_ptr_q;
      ovf_d    = 1'b0;
    end
    if (!PACKET_MODE || commit) cm_ptr_d = wr_ptr_d;
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_sync_packet_fifo.sv
// tb_sync_packet_fifo: packet-mode instance against a queue model,
// streaming instance against directed expectations.
module tb_sync_packet_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          p_shift = 0, p_commit = 0, p_abort = 0, p_pop = 0;
  logic [W-1:0]  p_data = '0;
  logic          p_full, p_af, p_ovf, p_ne, p_ae;
  logic [LW-1:0] p_il, p_ol;
  logic [W-1:0]  p_q;

  logic          s_shift = 0, s_commit = 0, s_abort = 0, s_pop = 0;
  logic [W-1:0]  s_data = '0;
  logic          s_full, s_af, s_ovf, s_ne, s_ae;
  logic [LW-1:0] s_il, s_ol;
  logic [W-1:0]  s_q;

  sync_packet_fifo #(.WIDTH(W), .DEPTH(D), .PACKET_MODE(1'b1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .in_shift(p_shift), .in_data(p_data),
    .in_commit(p_commit), .in_abort(p_abort),
    .in_full(p_full), .in_almost_full(p_af),
    .in_level(p_il), .in_overflow(p_ovf),
    .out_pop(p_pop), .out_data(p_q),
    .out_nempty(p_ne), .out_almost_empty(p_ae),
    .out_level(p_ol)
  );

  sync_packet_fifo #(.WIDTH(W), .DEPTH(D), .PACKET_MODE(1'b0)) u_str (
    .clk(clk), .rst_n(rst_n),
    .in_shift(s_shift), .in_data(s_data),
    .in_commit(s_commit), .in_abort(s_abort),
    .in_full(s_full), .in_almost_full(s_af),
    .in_level(s_il), .in_overflow(s_ovf),
    .out_pop(s_pop), .out_data(s_q),
    .out_nempty(s_ne), .out_almost_empty(s_ae),
    .out_level(s_ol)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q_cm[$];
  logic [W-1:0] q_un[$];
  bit           m_ovf = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pkt();
    int il;
    int ol;
    il = q_cm.size() + q_un.size();
    ol = q_cm.size();
    check("p_in_level", 32'(p_il), il);
    check("p_out_level", 32'(p_ol), ol);
    check("p_in_full", 32'(p_full), 32'(il == D));
    check("p_almost_full", 32'(p_af), 32'(il >= D - 2));
    check("p_almost_empty", 32'(p_ae), 32'(ol <= 1));
    check("p_nempty", 32'(p_ne), 32'(ol != 0));
    check("p_overflow", 32'(p_ovf), 32'(m_ovf));
    if (ol != 0) check("p_out_data", 32'(p_q), 32'(q_cm[0]));
  endtask

  // One packet-DUT cycle: check current state, apply inputs, advance model.
  task automatic pcyc(bit sh, logic [W-1:0] d, bit cm, bit ab, bit pp);
    bit full;
    bit ne;
    check_pkt();
    p_shift = sh; p_data = d; p_commit = cm; p_abort = ab; p_pop = pp;
    full = (q_cm.size() + q_un.size()) == D;
    ne   = q_cm.size() != 0;
    @(posedge clk);
    if (pp && ne) void'(q_cm.pop_front());
    if (sh) begin
      if (!full) q_un.push_back(d);
      else m_ovf = 1;
    end
    if (ab) begin
      q_un.delete();
      m_ovf = 0;
    end else if (cm) begin
      foreach (q_un[i]) q_cm.push_back(q_un[i]);
      q_un.delete();
    end
    @(negedge clk);
    p_shift = 0; p_commit = 0; p_abort = 0; p_pop = 0;
  endtask

  task automatic pdrain();
    for (int i = 0; i < 2 * D && q_cm.size() != 0; i++)
      pcyc(0, '0, 0, 0, 1);
  endtask

  task automatic scyc(bit sh, logic [W-1:0] d, bit cm, bit ab, bit pp);
    s_shift = sh; s_data = d; s_commit = cm; s_abort = ab; s_pop = pp;
    @(posedge clk);
    @(negedge clk);
    s_shift = 0; s_commit = 0; s_abort = 0; s_pop = 0;
  endtask

  initial begin
    int prior;
    int len;
    bit abt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming instance
    check("s_rst_level", 32'(s_il), 0);
    check("s_rst_nempty", 32'(s_ne), 0);
    check("s_rst_ae", 32'(s_ae), 1);
    check("s_rst_full", 32'(s_full), 0);
    for (int i = 0; i < D; i++) begin
      scyc(1, W'(i), 0, 0, 0);
      check("s_fill_level", 32'(s_il), i + 1);
      check("s_fill_out_level", 32'(s_ol), i + 1);
    end
    check("s_full", 32'(s_full), 1);
    check("s_af", 32'(s_af), 1);
    scyc(1, 8'hFF, 0, 1, 0);
    check("s_ovf_level", 32'(s_il), D);
    check("s_ovf", 32'(s_ovf), 1);
    check("s_head0", 32'(s_q), 0);
    scyc(1, 8'hEE, 0, 0, 1);
    check("s_full_sp_level", 32'(s_il), D - 1);
    for (int i = 1; i < D; i++) begin
      check("s_pop_data", 32'(s_q), i);
      scyc(0, '0, 0, 0, 1);
    end
    check("s_drained", 32'(s_ne), 0);
    check("s_ovf_sticky", 32'(s_ovf), 1);
    scyc(1, 8'h55, 0, 0, 1);
    check("s_empty_sp_level", 32'(s_ol), 1);
    check("s_empty_sp_data", 32'(s_q), 8'h55);

    // Packet instance: directed
    pcyc(1, 8'hA1, 0, 0, 0);
    pcyc(1, 8'hA2, 0, 0, 0);
    check("A_nempty", 32'(p_ne), 0);
    check("A_in_level", 32'(p_il), 2);
    pcyc(1, 8'hA3, 1, 0, 0);
    check("A_out_level", 32'(p_ol), 3);
    check("A_head", 32'(p_q), 8'hA1);
    pdrain();
    prior = q_cm.size() + q_un.size();
    pcyc(1, 8'hB1, 0, 0, 0);
    pcyc(1, 8'hB2, 0, 0, 0);
    pcyc(1, 8'hB3, 0, 1, 0);
    check("B_level", 32'(p_il), prior);
    pcyc(1, 8'hC1, 1, 0, 0);
    check("C_head", 32'(p_q), 8'hC1);
    pdrain();
    pcyc(1, 8'hD1, 0, 0, 0);
    pcyc(1, 8'hD2, 1, 1, 0);
    check("CA_out_level", 32'(p_ol), 0);
    check("CA_in_level", 32'(p_il), 0);
    for (int i = 0; i < D; i++) pcyc(1, W'(8'h40 + i), i == D - 1, 0, 0);
    check("P_full", 32'(p_full), 1);
    pcyc(1, 8'hEE, 0, 0, 1);
    check("P_full_sp_level", 32'(p_il), D - 1);
    check("P_full_sp_ovf", 32'(p_ovf), 1);
    pcyc(0, '0, 0, 1, 0);
    pdrain();
    pcyc(1, 8'h5A, 1, 0, 1);
    check("P_empty_sp_level", 32'(p_ol), 1);
    pdrain();

    // Packet instance: random packets
    for (int k = 0; k < 100; k++) begin
      len = $urandom_range(1, 8);
      abt = ($urandom_range(0, 9) < 2);
      for (int j = 0; j < len; j++)
        pcyc(1, W'($urandom), (j == len - 1) && !abt,
             (j == len - 1) && abt, $urandom_range(0, 9) < 6);
      repeat ($urandom_range(0, 3))
        pcyc(0, '0, 0, 0, $urandom_range(0, 1));
    end

    // Mid-packet reset
    pcyc(1, 8'h11, 1, 0, 0);
    pcyc(1, 8'h12, 0, 0, 0);
    p_shift = 1; p_data = 8'h13;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p_shift = 0;
    q_cm.delete();
    q_un.delete();
    m_ovf = 0;
    check("rst_ae", 32'(p_ae), 1);
    check("rst_in_level", 32'(p_il), 0);
    check_pkt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
